// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the memory-mapped UART: register
//               offsets, CON bit positions, serial FSM state encoding and the
//               oversampling ratio. Optional interrupt support: UART_IRQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   // Register byte offsets inside the peripheral region
   localparam logic [7:0] UART_TXD_OFS = 8'h18;
   localparam logic [7:0] UART_RXD_OFS = 8'h1C;
   localparam logic [7:0] UART_CON_OFS = 8'h20;

   // CON register bit positions
   localparam int CON_RX_VALID  = 0;
   localparam int CON_TX_BUSY   = 1;
   localparam int CON_FRAME_ERR = 2;
   localparam int CON_OVERRUN   = 3;
   localparam int CON_RX_IE     = 4;
   localparam int CON_TX_IE     = 5;
   localparam int CON_TX_DONE   = 6;

   // Baud ticks per serial bit
   localparam int OVERSAMPLE = 16;

   // State encoding shared by the RX and TX engines
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : Serial receiver. Two-flop synchronizer, start-bit validation
//               at mid-bit, 8 data bits LSB first, stop-bit check. Emits a
//               one-cycle o_byte_done or o_frame_err pulse per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
   import uart_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       i_tick,
   input  logic       i_rx,
   output logic       o_byte_done,
   output logic       o_frame_err,
   output logic [7:0] o_data
);

   localparam logic [3:0] c_LAST      = 4'(OVERSAMPLE - 1);
   localparam logic [3:0] c_HALF_LAST = 4'(OVERSAMPLE / 2 - 1);

   logic [1:0]  r_sync;
   logic        w_rx;
   uart_state_t r_state;
   logic [3:0]  r_phase;
   logic [2:0]  r_bit;
   logic [7:0]  r_shift;
   logic [7:0]  r_data;
   logic        r_done;
   logic        r_ferr;

   assign w_rx = r_sync[1];

   // Synchronize the asynchronous serial line; reset to idle-high so reset
   // release never looks like a start bit.
   always_ff @(posedge clk) begin
      if (reset) r_sync <= 2'b11;
      else       r_sync <= {r_sync[0], i_rx};
   end

   // Receive FSM: sample mid-bit, shift LSB first, pulse result at stop bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_phase <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_data  <= '0;
         r_done  <= 1'b0;
         r_ferr  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_ferr <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (!w_rx) begin
                  r_state <= ST_START;
                  r_phase <= '0;
               end
            end
            ST_START: begin
               if (i_tick) begin
                  if (r_phase == c_HALF_LAST) begin
                     // Line must still be low at mid start bit, else a glitch
                     r_phase <= '0;
                     r_bit   <= '0;
                     r_state <= w_rx ? ST_IDLE : ST_DATA;
                  end else begin
                     r_phase <= r_phase + 4'd1;
                  end
               end
            end
            ST_DATA: begin
               if (i_tick) begin
                  if (r_phase == c_LAST) begin
                     r_phase <= '0;
                     r_shift <= {w_rx, r_shift[7:1]};
                     if (r_bit == 3'd7) r_state <= ST_STOP;
                     else               r_bit   <= r_bit + 3'd1;
                  end else begin
                     r_phase <= r_phase + 4'd1;
                  end
               end
            end
            ST_STOP: begin
               if (i_tick) begin
                  if (r_phase == c_LAST) begin
                     if (w_rx) begin
                        r_data <= r_shift;
                        r_done <= 1'b1;
                     end else begin
                        r_ferr <= 1'b1;
                     end
                     r_state <= ST_IDLE;
                  end else begin
                     r_phase <= r_phase + 4'd1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_byte_done = r_done;
   assign o_frame_err = r_ferr;
   assign o_data      = r_data;

endmodule
`default_nettype wire

// File: rtl/uart_mmio.sv
`default_nettype none
// ============================================================================
// Module      : uart_mmio
// Description : Memory-mapped UART on the data-memory bus (region
//               addr[30:28] == 4). Baud tick generator, transmit FSM,
//               TXD/RXD/CON register file and combinational read mux.
//               Define UART_IRQ_EN to implement rx_ie/tx_ie and irq.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_mmio
   import uart_pkg::*;
#(
   parameter int BAUD_DIV = 651
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic        rx,
   output logic        tx,
   output logic        irq
);

   localparam int         c_CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [c_CNT_W-1:0] c_BAUD_LAST = c_CNT_W'(BAUD_DIV - 1);
   localparam logic [3:0] c_LAST = 4'(OVERSAMPLE - 1);

   // ---------------- baud tick ----------------
   logic [c_CNT_W-1:0] r_baud;
   logic               w_tick;

   assign w_tick = (r_baud == c_BAUD_LAST);

   // Free-running divider shared by both serial engines.
   always_ff @(posedge clk) begin
      if (reset)       r_baud <= '0;
      else if (w_tick) r_baud <= '0;
      else             r_baud <= r_baud + c_CNT_W'(1);
   end

   // ---------------- bus decode ----------------
   logic w_region, w_sel_txd, w_sel_rxd, w_sel_con;
   logic w_txd_wr, w_con_wr, w_rxd_rd;

   assign w_region  = (addr[30:28] == 3'd4);
   assign w_sel_txd = w_region && (addr[7:0] == UART_TXD_OFS);
   assign w_sel_rxd = w_region && (addr[7:0] == UART_RXD_OFS);
   assign w_sel_con = w_region && (addr[7:0] == UART_CON_OFS);
   assign w_txd_wr  = wr && w_sel_txd;
   assign w_con_wr  = wr && w_sel_con;
   assign w_rxd_rd  = rd && w_sel_rxd;

   // ---------------- receiver ----------------
   logic       w_rx_done;
   logic       w_rx_ferr;
   logic [7:0] w_rx_byte;

   uart_rx u_rx (
      .clk         (clk),
      .reset       (reset),
      .i_tick      (w_tick),
      .i_rx        (rx),
      .o_byte_done (w_rx_done),
      .o_frame_err (w_rx_ferr),
      .o_data      (w_rx_byte)
   );

   // ---------------- transmitter ----------------
   uart_state_t r_tx_state;
   logic [3:0]  r_tx_phase;
   logic [2:0]  r_tx_bit;
   logic [7:0]  r_tx_shift;
   logic        r_tx;
   logic        r_tx_busy;
   logic        r_tx_end;

   // Transmit FSM. A write while idle only arms the engine; the start bit
   // begins on the next tick so every bit lasts exactly OVERSAMPLE ticks.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tx_state <= ST_IDLE;
         r_tx_phase <= '0;
         r_tx_bit   <= '0;
         r_tx_shift <= '0;
         r_tx       <= 1'b1;
         r_tx_busy  <= 1'b0;
         r_tx_end   <= 1'b0;
      end else begin
         r_tx_end <= 1'b0;
         case (r_tx_state)
            ST_IDLE: begin
               if (w_txd_wr && !r_tx_busy) begin
                  r_tx_shift <= wdata[7:0];
                  r_tx_busy  <= 1'b1;
               end else if (r_tx_busy && w_tick) begin
                  r_tx_state <= ST_START;
                  r_tx       <= 1'b0;
                  r_tx_phase <= '0;
               end
            end
            ST_START: begin
               if (w_tick) begin
                  if (r_tx_phase == c_LAST) begin
                     r_tx_state <= ST_DATA;
                     r_tx       <= r_tx_shift[0];
                     r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                     r_tx_phase <= '0;
                     r_tx_bit   <= '0;
                  end else begin
                     r_tx_phase <= r_tx_phase + 4'd1;
                  end
               end
            end
            ST_DATA: begin
               if (w_tick) begin
                  if (r_tx_phase == c_LAST) begin
                     r_tx_phase <= '0;
                     if (r_tx_bit == 3'd7) begin
                        r_tx_state <= ST_STOP;
                        r_tx       <= 1'b1;
                     end else begin
                        r_tx       <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        r_tx_bit   <= r_tx_bit + 3'd1;
                     end
                  end else begin
                     r_tx_phase <= r_tx_phase + 4'd1;
                  end
               end
            end
            ST_STOP: begin
               if (w_tick) begin
                  if (r_tx_phase == c_LAST) begin
                     r_tx_state <= ST_IDLE;
                     r_tx_busy  <= 1'b0;
                     r_tx_end   <= 1'b1;
                  end else begin
                     r_tx_phase <= r_tx_phase + 4'd1;
                  end
               end
            end
            default: r_tx_state <= ST_IDLE;
         endcase
      end
   end

   assign tx = r_tx;

   // ---------------- register file ----------------
   logic [7:0] r_txd_last;
   logic [7:0] r_rx_data;
   logic       r_rx_valid;
   logic       r_frame_err;
   logic       r_overrun;
   logic       r_tx_done;
   logic       w_rx_ie;
   logic       w_tx_ie;

   // Status flags. Clears are written before sets so a same-cycle set wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_txd_last  <= '0;
         r_rx_data   <= '0;
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
         r_tx_done   <= 1'b0;
      end else begin
         if (w_txd_wr) r_txd_last <= wdata[7:0];

         if (w_con_wr && wdata[CON_FRAME_ERR]) r_frame_err <= 1'b0;
         if (w_con_wr && wdata[CON_OVERRUN])   r_overrun   <= 1'b0;
         if (w_con_wr && wdata[CON_TX_DONE])   r_tx_done   <= 1'b0;

         if (w_rx_done) begin
            // A byte arriving while the old one is being read is not an overrun
            r_rx_data  <= w_rx_byte;
            r_rx_valid <= 1'b1;
            if (r_rx_valid && !w_rxd_rd) r_overrun <= 1'b1;
         end else if (w_rxd_rd) begin
            r_rx_valid <= 1'b0;
         end

         if (w_rx_ferr) r_frame_err <= 1'b1;
         if (r_tx_end)  r_tx_done   <= 1'b1;
      end
   end

`ifdef UART_IRQ_EN
   logic r_rx_ie;
   logic r_tx_ie;

   // Interrupt enables, plain read/write bits in CON.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rx_ie <= 1'b0;
         r_tx_ie <= 1'b0;
      end else if (w_con_wr) begin
         r_rx_ie <= wdata[CON_RX_IE];
         r_tx_ie <= wdata[CON_TX_IE];
      end
   end

   assign w_rx_ie = r_rx_ie;
   assign w_tx_ie = r_tx_ie;
`else
   assign w_rx_ie = 1'b0;
   assign w_tx_ie = 1'b0;
`endif

   assign irq = (r_rx_valid & w_rx_ie) | (r_tx_done & w_tx_ie);

   // ---------------- read mux ----------------
   logic [31:0] w_con;

   // Assemble CON and select the addressed register; zero when not reading.
   always_comb begin
      w_con                = 32'h0;
      w_con[CON_RX_VALID]  = r_rx_valid;
      w_con[CON_TX_BUSY]   = r_tx_busy;
      w_con[CON_FRAME_ERR] = r_frame_err;
      w_con[CON_OVERRUN]   = r_overrun;
      w_con[CON_RX_IE]     = w_rx_ie;
      w_con[CON_TX_IE]     = w_tx_ie;
      w_con[CON_TX_DONE]   = r_tx_done;
      rdata                = 32'h0;
      if (rd) begin
         if (w_sel_txd)      rdata = {24'h0, r_txd_last};
         else if (w_sel_rxd) rdata = {24'h0, r_rx_data};
         else if (w_sel_con) rdata = w_con;
      end
   end

   // Address/data bits outside the decoded fields are intentionally ignored.
   logic w_unused;
   assign w_unused = ^{addr[31], addr[27:8], wdata[31:8]};

endmodule
`default_nettype wire

// File: tb/tb_uart_mmio.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_mmio
// Description : Self-checking bench for uart_mmio (BAUD_DIV = 4, 64 clocks
//               per bit). Register vectors from a table, TX waveforms and
//               RX flag behaviour compared with a frame-level model.
//               Interrupt checks follow UART_IRQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_mmio;

   localparam int          c_BIT  = 64;
   localparam logic [31:0] c_TXD  = 32'h4000_0018;
   localparam logic [31:0] c_RXD  = 32'h4000_001C;
   localparam logic [31:0] c_CON  = 32'h4000_0020;
`ifdef UART_IRQ_EN
   localparam logic [31:0] c_IE   = 32'h30;
`else
   localparam logic [31:0] c_IE   = 32'h0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic [31:0] rdata;
   logic        rx = 1'b1;
   logic        tx;
   logic        irq;

   int n_checks = 0;
   int n_errors = 0;

   uart_mmio #(.BAUD_DIV(4)) dut (
      .clk   (clk),
      .reset (reset),
      .rd    (rd),
      .wr    (wr),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata),
      .rx    (rx),
      .tx    (tx),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      wr = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      wr = 1'b0;
   endtask

   // Read across one rising edge (RXD reads have a side effect)
   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk);
      rd = 1'b1; addr = a;
      #1 d = rdata;
      @(negedge clk);
      rd = 1'b0;
   endtask

   // Combinational look at a register without crossing a clock edge
   task automatic peek(input logic [31:0] a, input logic use_rd, output logic [31:0] d);
      rd = use_rd; addr = a;
      #1 d = rdata;
      rd = 1'b0;
   endtask

   // Drive one serial frame; stop_low holds the stop bit low across its sample
   task automatic send_rx(input logic [7:0] b, input logic stop_low);
      @(negedge clk);
      rx = 1'b0;
      repeat (c_BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (c_BIT) @(negedge clk);
      end
      if (stop_low) begin
         rx = 1'b0;
         repeat (40) @(negedge clk);
         rx = 1'b1;
         repeat (24) @(negedge clk);
      end else begin
         rx = 1'b1;
         repeat (c_BIT) @(negedge clk);
      end
   endtask

   // Transmit a byte and compare each bit centre with the expected frame
   task automatic tx_frame(input logic [7:0] b, input logic midwrite);
      logic [9:0]  fr;
      logic [31:0] d;
      int          w;
      fr = {1'b1, b, 1'b0};
      bus_write(c_TXD, {24'h0, b});
      w = 0;
      while (tx !== 1'b0 && w < 20) begin
         @(negedge clk);
         w++;
      end
      check("tx_start_bit_seen", {31'h0, tx}, 32'h0);
      if (tx !== 1'b0) return;
      rd = 1'b1; addr = c_CON;
      for (int c = 1; c <= 10 * c_BIT; c++) begin
         @(negedge clk);
         if (midwrite && c == 200) begin
            rd = 1'b0; wr = 1'b1; addr = c_TXD; wdata = {24'h0, ~b};
         end
         if (midwrite && c == 201) begin
            wr = 1'b0; rd = 1'b1; addr = c_CON;
         end
         if (c % c_BIT == c_BIT / 2) begin
            #1;
            check($sformatf("tx_bit%0d_of_%h", c / c_BIT, b), {31'h0, tx}, {31'h0, fr[c / c_BIT]});
            check($sformatf("tx_busy_bit%0d", c / c_BIT), {31'h0, rdata[1]}, 32'h1);
         end
      end
      rd = 1'b0;
      repeat (3) @(negedge clk);
      peek(c_CON, 1'b1, d);
      check("con_tx_done_after_frame", d, 32'h40);
      check("tx_idle_high", {31'h0, tx}, 32'h1);
      bus_write(c_CON, 32'h40);
      peek(c_CON, 1'b1, d);
      check("con_tx_done_cleared", d, 32'h0);
   endtask

   typedef struct {
      int          op;     // 0 write, 1 read with rd, 2 look with rd low
      logic [31:0] a;
      logic [31:0] d;      // write data or expected read data
   } vec_t;

   vec_t        vecs[15];
   logic [31:0] d;
   logic        m_valid, m_over;
   logic [7:0]  m_data, b;

   initial begin
      vecs[0]  = '{1, c_CON,          32'h0};
      vecs[1]  = '{1, c_RXD,          32'h0};
      vecs[2]  = '{1, c_TXD,          32'h0};
      vecs[3]  = '{0, c_CON,          32'h4C};
      vecs[4]  = '{1, c_CON,          32'h0};
      vecs[5]  = '{0, c_CON,          32'h30};
      vecs[6]  = '{1, c_CON,          c_IE};
      vecs[7]  = '{1, 32'h3000_0020,  32'h0};
      vecs[8]  = '{1, 32'h4000_0024,  32'h0};
      vecs[9]  = '{2, c_CON,          32'h0};
      vecs[10] = '{1, 32'hC000_0020,  c_IE};
      vecs[11] = '{0, c_CON,          32'h0};
      vecs[12] = '{0, 32'h2000_0018,  32'h5A};
      vecs[13] = '{1, c_TXD,          32'h0};
      vecs[14] = '{1, c_CON,          32'h0};

      // Reset state
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset_tx", {31'h0, tx}, 32'h1);
      check("reset_irq", {31'h0, irq}, 32'h0);
      peek(c_CON, 1'b1, d);
      check("reset_con", d, 32'h0);

      // Register-level vectors
      foreach (vecs[i]) begin
         if (vecs[i].op == 0) begin
            bus_write(vecs[i].a, vecs[i].d);
         end else begin
            peek(vecs[i].a, (vecs[i].op == 1), d);
            check($sformatf("vec%0d_rdata", i), d, vecs[i].d);
         end
      end

      // Directed transmit with an ignored write mid-frame
      tx_frame(8'hA5, 1'b1);
      peek(c_TXD, 1'b1, d);
      check("txd_last_written", d, 32'h0000_005A);
      for (int k = 0; k < 3; k++) tx_frame(8'($urandom_range(0, 255)), 1'b0);

      // Single receive
      send_rx(8'h3C, 1'b0);
      peek(c_CON, 1'b1, d);
      check("rx_valid_set", d, 32'h1);
      bus_read(c_RXD, d);
      check("rxd_3c", d, 32'h3C);
      peek(c_CON, 1'b1, d);
      check("rx_valid_cleared", d, 32'h0);

      // Overrun
      send_rx(8'h11, 1'b0);
      send_rx(8'h22, 1'b0);
      peek(c_CON, 1'b1, d);
      check("overrun_con", d, 32'h9);
      bus_read(c_RXD, d);
      check("overrun_newest_byte", d, 32'h22);
      bus_write(c_CON, 32'h8);
      peek(c_CON, 1'b1, d);
      check("overrun_w1c", d, 32'h0);

      // Random receive stream against a frame-level flag model
      m_valid = 1'b0; m_over = 1'b0; m_data = 8'h0;
      for (int k = 0; k < 6; k++) begin
         b = 8'($urandom_range(0, 255));
         send_rx(b, 1'b0);
         if (m_valid) m_over = 1'b1;
         m_valid = 1'b1;
         m_data  = b;
         peek(c_CON, 1'b1, d);
         check($sformatf("rand_rx%0d_con", k), d, {28'h0, m_over, 2'b00, m_valid});
         if ($urandom_range(0, 1) == 1) begin
            bus_read(c_RXD, d);
            check($sformatf("rand_rx%0d_data", k), d, {24'h0, m_data});
            m_valid = 1'b0;
         end
      end
      bus_read(c_RXD, d);
      check("rand_rx_final_data", d, {24'h0, m_data});
      bus_write(c_CON, 32'h8);
      peek(c_CON, 1'b1, d);
      check("rand_rx_cleanup", d, 32'h0);

      // Framing error, then a short glitch, then a good byte
      send_rx(8'h55, 1'b1);
      repeat (20) @(negedge clk);
      peek(c_CON, 1'b1, d);
      check("frame_err_con", d, 32'h4);
      bus_write(c_CON, 32'h4);
      rx = 1'b0;
      repeat (20) @(negedge clk);
      rx = 1'b1;
      repeat (100) @(negedge clk);
      peek(c_CON, 1'b1, d);
      check("glitch_no_flags", d, 32'h0);
      send_rx(8'h5A, 1'b0);
      bus_read(c_RXD, d);
      check("after_glitch_rxd", d, 32'h5A);

      // Interrupt behaviour
`ifdef UART_IRQ_EN
      bus_write(c_CON, 32'h10);
      check("irq_idle", {31'h0, irq}, 32'h0);
      send_rx(8'h7E, 1'b0);
      check("irq_rx_set", {31'h0, irq}, 32'h1);
      peek(c_CON, 1'b1, d);
      check("irq_con", d, 32'h11);
      bus_read(c_RXD, d);
      check("irq_rxd", d, 32'h7E);
      check("irq_rx_cleared", {31'h0, irq}, 32'h0);
      bus_write(c_CON, 32'h0);
`else
      bus_write(c_CON, 32'h30);
      send_rx(8'h7E, 1'b0);
      check("irq_tied_low", {31'h0, irq}, 32'h0);
      peek(c_CON, 1'b1, d);
      check("irq_con_no_ie", d, 32'h1);
      bus_read(c_RXD, d);
      check("irq_rxd", d, 32'h7E);
`endif

      // Reset in the middle of a transmit
      bus_write(c_TXD, 32'hC3);
      repeat (200) @(negedge clk);
      check("pre_reset_tx_low", {31'h0, tx}, 32'h0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("reset_mid_tx", {31'h0, tx}, 32'h1);
      @(negedge clk);
      reset = 1'b0;
      peek(c_CON, 1'b1, d);
      check("reset_mid_tx_con", d, 32'h0);
      repeat (700) @(negedge clk);
      check("reset_tx_stays_idle", {31'h0, tx}, 32'h1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_mmio.md
# uart_mmio

Memory-mapped UART peripheral on the data-memory bus, decoded in the peripheral region (Address[30:28] == 3'd4) next to the timer/LED/digit registers. Its `rdata` feeds the data-memory read mux. It receives bytes from the host PC and transmits result bytes back, so sort input and output move over the serial line. It provides one transmit holding path, one receive buffer, a status/control register and an optional interrupt.

## Interface
- `BAUD_DIV`, 651: clk cycles per oversample tick. A bit lasts 16 ticks; 651 gives ≈9600 baud at 100 MHz.
- `clk` input 1: system clock. All logic is on the rising edge.
- `reset` input 1: **synchronous, active-high** reset, sampled on the `clk` rising edge.
- `rd` input 1: bus read strobe (MemRead).
- `wr` input 1: bus write strobe (MemWrite).
- `addr` input 32: bus address. The block is selected when addr[30:28] == 3'd4 and addr[7:0] matches a register below.
- `wdata` input 32: bus write data.
- `rdata` output 32: read data. Combinational; 32'h0 when not selected or when `rd` = 0.
- `rx` input 1: serial input. Asynchronous; goes through a 2-flop synchronizer.
- `tx` output 1: serial output. Idle high.
- `irq` output 1: level interrupt request.

## Operation
- **Register map** (byte offsets):
  - 0x18 TXD (W): wdata[7:0] starts a transmit when TX is idle. Ignored while busy. Reads return {24'h0, last byte written}.
  - 0x1C RXD (R): {24'h0, rx_data}. A read clears rx_valid at the clock edge.
  - 0x20 CON (R/W):
    - bit0 rx_valid (R)
    - bit1 tx_busy (R)
    - bit2 frame_err (R, write 1 to clear)
    - bit3 overrun (R, write 1 to clear)
    - bit4 rx_ie (R/W)
    - bit5 tx_ie (R/W)
    - bit6 tx_done (R, write 1 to clear)
- **Baud tick**: a free-running counter 0..BAUD_DIV-1 pulses `tick` for one cycle on wrap. RX and TX share it.
- **RX FSM** (IDLE, START, DATA, STOP):
  - IDLE → START on synchronized rx = 0. The tick phase counter is cleared on entry.
  - START: after 8 ticks, rx still 0 → DATA; rx = 1 → IDLE (glitch rejected, no flags).
  - DATA: sample every 16 ticks, LSB first, 8 bits → STOP.
  - STOP: sample after 16 ticks.
    - rx = 1: load rx_data and set rx_valid. If rx_valid was already 1, also set overrun; the new byte overwrites the old one.
    - rx = 0: set frame_err, discard the byte, leave rx_valid unchanged.
    - Either way → IDLE.
- **TX FSM** (IDLE, START, DATA, STOP):
  - A TXD write in IDLE latches the byte and sets tx_busy on the next edge.
  - Each bit is driven for 16 ticks: start 0, d0..d7, stop 1.
  - At the end of STOP: clear tx_busy, set tx_done, → IDLE.
  - A TXD write while busy is dropped silently.
- **irq** = (rx_valid & rx_ie) | (tx_done & tx_ie).
- **Simultaneous events**:
  - RX completion in the same cycle as an RXD read: the new byte wins, rx_valid stays 1, no overrun.
  - A W1C write in the same cycle as a flag set: the set wins.

## Timing
- Reset values: tx = 1, rdata = 0 (combinational), irq = 0. All flags, rx_ie, tx_ie, rx_data and counters are 0; both FSMs are in IDLE.
- Reset mid-frame aborts immediately. tx is 1 after the reset edge; no partial byte is stored.
- Register writes take effect at the rising edge where wr, select and the offset are all true.
- Reads are zero-latency combinational.
- tx falls within 1 tick (≤ BAUD_DIV cycles) after the TXD write edge. A frame lasts 160 ticks from start edge to end of stop.
- rx_valid rises 2–3 cycles (synchronizer) plus up to 1 tick after the mid-stop-bit sample.

## Configuration
- `UART_IRQ_EN` defined: rx_ie and tx_ie are implemented and `irq` behaves as above.
- `UART_IRQ_EN` undefined: `irq` is tied to 0, CON bits 4–5 read as 0, and writes to them are ignored. All other behaviour is identical.

## Structure
- Package `uart_pkg` holds:
  - offsets UART_TXD_OFS = 8'h18, UART_RXD_OFS = 8'h1C, UART_CON_OFS = 8'h20;
  - CON bit indices;
  - the shared state enum {IDLE, START, DATA, STOP};
  - OVERSAMPLE = 16.
- Sub-module `uart_rx`: synchronizer, RX FSM and shift register. It outputs a one-cycle byte_done/frame_err pulse and data[7:0].
- The top level holds the baud tick, the TX FSM, the register file and the bus decode.

## Test plan
Benches use BAUD_DIV = 4, i.e. 64 cycles per bit.
- Reset then idle → tx = 1, CON reads 0, irq = 0.
- Write TXD = 8'hA5 → tx shows 0,1,0,1,0,0,1,0,1,1 with 64 cycles per bit. tx_busy is 1 during the frame. tx_done = 1 afterwards. A second write mid-frame does not alter the waveform.
- Drive rx frame 8'h3C → CON bit0 = 1, RXD reads 32'h3C, and bit0 = 0 after the read cycle.
- Two frames (8'h11, 8'h22) with no read in between → RXD = 32'h22, overrun = 1. Writing CON = 32'h8 clears overrun.
- Stop bit held 0 → frame_err = 1, rx_valid stays 0. A 20-cycle rx low glitch → no flags, FSM back in IDLE.
- With UART_IRQ_EN: CON = 32'h10, then receive 8'h7E → irq = 1 until RXD is read. Assert reset mid-TX-frame → tx = 1 at the next edge, tx_busy = 0.
